mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multi-cycle control unit for the MIPS core. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback, and drives every datapath strobe and mux select. It stalls on a single memory ready handshake shared by instruction and data accesses. It also counts retired instructions and flags illegal encodings.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26], stable from DECODE until return to FETCH
- funct  in  6  IR[5:0], same stability
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond  out  1  PC load / PC load if ALU zero
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_read, mem_write, ir_write  out  1  memory strobes / IR load
- reg_write, reg_dst, mem_to_reg  out  1  regfile write, 1 = rd (else rt), 1 = MDR (else ALUOut)
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding, debug
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  one-cycle pulse on an unsupported encoding
- instr_count  out  CNT_W  retired-instruction count

## Operation
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_EX 8, ADDI_EX 9, ADDI_WB 10, J_EX 11. Codes 12–15 are unreachable; if entered, go to FETCH.
- Supported opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j.
- Supported R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Advance to DECODE only when mem_ready=1; otherwise hold.
- DECODE:
  - alu_src_a=0, alu_src_b=11, add (computes branch target).
  - Next state by opcode: lw/sw→MEMADR, R→RTYPE_EX, beq→BEQ_EX, addi→ADDI_EX, j→J_EX.
  - Unsupported opcode, or R-type with unsupported funct: illegal_op=1 for this cycle, next FETCH, no retire, no writes.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1. Next FETCH.
- MEMWR:
  - mem_write=1, iord=1. Hold until mem_ready.
  - On the mem_ready cycle: retire=1, next FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_ctrl decoded from funct. Next RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctrl held from funct, retire=1. Next FETCH.
- BEQ_EX: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01, retire=1. Next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, add. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1. Next FETCH.
- J_EX: pc_write=1, pc_source=10, retire=1. Next FETCH.
- instr_count:
  - Increments by 1 on each clock edge where retire=1.
  - Wraps from all-ones to 0 with no flag.

## Timing
- State register and instr_count are the only flops; all strobes decode combinationally from state and the inputs.
- Reset (sampled at a clock edge): state←FETCH, instr_count←0.
  - While reset=1, every strobe, retire and illegal_op is forced to 0; state reads 0.
  - Reset wins over any in-flight instruction, including a pending MEMWR. No partial retire.
- Cycles per instruction with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes stay asserted and stable while waiting.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- retire and illegal_op are never high in the same cycle.

## Test plan
- Reset while in MEMWR with mem_ready=0 → next cycle state=0, mem_write=0, instr_count=0. Release reset → FETCH asserts mem_read=1.
- mem_ready=1 constant, sequence lw, sw, add (funct 100000), beq, addi, j → 5+4+4+3+4+3 = 23 cycles, instr_count=6, retire pulses at cycles 5, 9, 13, 16, 20, 23.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD → 10 cycles total; mem_read and iord stable during each wait; ir_write high only on the FETCH ready cycle.
- Opcode 111111 → illegal_op pulse in DECODE, return to FETCH, instr_count unchanged, reg_write/mem_write never high.
- R-type with funct 100101 → alu_ctrl=001 in RTYPE_EX; R-type with funct 000000 → illegal_op.
- Preload-free wrap check with CNT_W=3: retire 8 instructions → instr_count returns to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction fields, memory handshake and datapath strobes of the control unit
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             retire;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
               pc_source, state, retire, illegal_op, instr_count
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
               pc_source, state, retire, illegal_op, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with memory stall, retire counter and illegal-op flag
module mips_multicycle_ctrl #(parameter int CNT_W = 32) (
    input logic clock,
    input logic reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        RTYPE_EX = 4'd6, RTYPE_WB = 4'd7, BEQ_EX = 4'd8, ADDI_EX = 4'd9, ADDI_WB = 4'd10, J_EX = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       retire;
        logic       illegal_op;
    } ctl_t;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;
    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110;

    state_t           st, nx;
    ctl_t             c;
    logic [CNT_W-1:0] cnt;
    logic             rdy;
    logic             fn_ok;
    logic [2:0]       fn_alu;

    assign rdy = bus.mem_ready;

    // funct decode for R-type ALU operation and legality
    always_comb begin
        fn_ok  = (bus.funct == FN_ADD) || (bus.funct == FN_SUB) || (bus.funct == FN_AND) ||
                 (bus.funct == FN_OR) || (bus.funct == FN_SLT);
        fn_alu = (bus.funct == FN_SUB) ? ALU_SUB :
                 (bus.funct == FN_AND) ? 3'b000 :
                 (bus.funct == FN_OR)  ? 3'b001 :
                 (bus.funct == FN_SLT) ? 3'b111 : ALU_ADD;
    end

    // Moore strobes and next state; reset blanks every strobe so an aborted access never retires
    always_comb begin
        c  = '0;
        nx = FETCH;
        case (st)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_ctrl  = ALU_ADD;
                c.ir_write  = rdy;
                c.pc_write  = rdy;
                nx          = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctrl  = ALU_ADD;
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) nx = MEMADR;
                else if (bus.opcode == OP_R && fn_ok) nx = RTYPE_EX;
                else if (bus.opcode == OP_BEQ) nx = BEQ_EX;
                else if (bus.opcode == OP_ADDI) nx = ADDI_EX;
                else if (bus.opcode == OP_J) nx = J_EX;
                else c.illegal_op = 1'b1;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = ALU_ADD;
                nx          = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                nx         = rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                c.retire    = rdy;
                nx          = rdy ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_ctrl  = fn_alu;
                nx          = RTYPE_WB;
            end
            RTYPE_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_ctrl  = fn_alu;
                c.retire    = 1'b1;
            end
            BEQ_EX: begin
                c.alu_src_a     = 1'b1;
                c.alu_ctrl      = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.retire        = 1'b1;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = ALU_ADD;
                nx          = ADDI_WB;
            end
            ADDI_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            J_EX: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.retire    = 1'b1;
            end
            default: nx = FETCH;
        endcase
        if (reset) c = '0;
    end

    // state register and retired-instruction counter
    always_ff @(posedge clock) begin
        if (reset) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st  <= nx;
            cnt <= cnt + CNT_W'(c.retire);
        end
    end

    assign bus.pc_write      = c.pc_write;
    assign bus.pc_write_cond = c.pc_write_cond;
    assign bus.iord          = c.iord;
    assign bus.mem_read      = c.mem_read;
    assign bus.mem_write     = c.mem_write;
    assign bus.ir_write      = c.ir_write;
    assign bus.reg_write     = c.reg_write;
    assign bus.reg_dst       = c.reg_dst;
    assign bus.mem_to_reg    = c.mem_to_reg;
    assign bus.alu_src_a     = c.alu_src_a;
    assign bus.alu_src_b     = c.alu_src_b;
    assign bus.alu_ctrl      = c.alu_ctrl;
    assign bus.pc_source     = c.pc_source;
    assign bus.retire        = c.retire;
    assign bus.illegal_op    = c.illegal_op;
    assign bus.state         = reset ? 4'd0 : st;
    assign bus.instr_count   = cnt;
endmodule
